// File: rtl/fpu_arb_pkg.sv
// fpu_arbiter shared types: FSM state encoding, FPU op codes, default widths.
// Optional watchdog is enabled by defining FPU_ARB_TIMEOUT_EN.
package fpu_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fpu_arb_state_t;

  localparam logic [1:0] FPU_OP_ADD = 2'd0;
  localparam logic [1:0] FPU_OP_SUB = 2'd1;
  localparam logic [1:0] FPU_OP_MUL = 2'd2;
  localparam logic [1:0] FPU_OP_DIV = 2'd3;

  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_OP_W        = 2;
  localparam int DEF_TIMEOUT_CYC = 64;

endpackage

// File: rtl/fpu_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr,
// wrapping, as a one-hot grant plus its encoded index.
module rr_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  int   j;
  logic found;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin sequencer sharing one non-pipelined FPU among NUM_REQ agents.
// Define FPU_ARB_TIMEOUT_EN to add the WAIT-state watchdog and rsp_err.
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OP_W        = DEF_OP_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_din1,
  input  logic [NUM_REQ*DATA_W-1:0] req_din2,
  input  logic [NUM_REQ*OP_W-1:0]   req_op,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_result,
  output logic                      rsp_err,
  output logic [DATA_W-1:0]         fpu_din1,
  output logic [DATA_W-1:0]         fpu_din2,
  output logic [OP_W-1:0]           fpu_op_sel,
  output logic                      fpu_valid,
  input  logic [DATA_W-1:0]         fpu_result,
  input  logic                      fpu_ready,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  fpu_arb_state_t   state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic             tmo;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = (state == ST_IDLE) ? gnt : '0;

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign tmo     = (cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_err = err_q;

  // Counter sits at zero outside WAIT, so it restarts on every WAIT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= (state == ST_WAIT) ? cnt + 1'b1 : '0;
      err_q <= (state == ST_WAIT) && !fpu_ready && tmo;
    end
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gidx       <= '0;
      fpu_din1   <= '0;
      fpu_din2   <= '0;
      fpu_op_sel <= '0;
      fpu_valid  <= 1'b0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|req_valid) begin
            gidx       <= gnt_idx;
            fpu_din1   <= req_din1[gnt_idx*DATA_W +: DATA_W];
            fpu_din2   <= req_din2[gnt_idx*DATA_W +: DATA_W];
            fpu_op_sel <= req_op[gnt_idx*OP_W +: OP_W];
            fpu_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          fpu_valid <= 1'b0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // A real result wins over a watchdog expiry in the same cycle.
          if (fpu_ready || tmo) begin
            rsp_result <= fpu_ready ? fpu_result : '0;
            rsp_valid  <= NUM_REQ'(1) << gidx;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          ptr       <= (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed self-checking bench for fpu_arbiter with a latency-programmable
// FPU stub; the watchdog step runs only when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_din1;
  logic [127:0] req_din2;
  logic [7:0]   req_op;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_result;
  logic         rsp_err;
  logic [31:0]  fpu_din1;
  logic [31:0]  fpu_din2;
  logic [1:0]   fpu_op_sel;
  logic         fpu_valid;
  logic [31:0]  fpu_result;
  logic         fpu_ready;
  logic         busy;

  logic         mdl_ready;
  logic         spur;
  int           lat;
  int           mdl_cnt;
  logic         mdl_mute;
  logic         mdl_fixed;
  logic [31:0]  mdl_d;

  int checks = 0;
  int errors = 0;

  logic [31:0] d1 [4] = '{32'h3F800000, 32'h42000000, 32'h43000000, 32'h44000000};
  logic [31:0] d2 [4] = '{32'h40000000, 32'h000000FF, 32'h000000FF, 32'h000000FF};
  logic [31:0] rx [4] = '{32'h7F800000, 32'h420000FF, 32'h430000FF, 32'h440000FF};

  always #5 clk = ~clk;

  fpu_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_din1   (req_din1),
    .req_din2   (req_din2),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .fpu_din1   (fpu_din1),
    .fpu_din2   (fpu_din2),
    .fpu_op_sel (fpu_op_sel),
    .fpu_valid  (fpu_valid),
    .fpu_result (fpu_result),
    .fpu_ready  (fpu_ready),
    .busy       (busy)
  );

  assign fpu_ready = mdl_ready | spur;

  // FPU stub: pulses ready lat cycles after the issue cycle.
  always @(negedge clk) begin
    mdl_ready = 1'b0;
    if (fpu_valid) begin
      mdl_cnt = lat;
      mdl_d   = fpu_din1 ^ fpu_din2;
    end else if (mdl_cnt > 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0 && !mdl_mute) begin
        mdl_ready  = 1'b1;
        fpu_result = mdl_fixed ? 32'h40400000 : mdl_d;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(input string tag, input logic [3:0] ev,
                          input logic [31:0] er, input logic ee);
    int n = 0;
    tick();
    while (rsp_valid == 4'b0 && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_v"}, 32'(rsp_valid), 32'(ev));
    chk({tag, "_r"}, rsp_result, er);
    chk({tag, "_e"}, 32'(rsp_err), 32'(ee));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin : timeout_guard
    #500000;
    $display("FAIL global_timeout observed=stuck expected=finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int hits;
    reset     = 1'b1;
    req_valid = 4'b0;
    spur      = 1'b0;
    lat       = 3;
    mdl_cnt   = 0;
    mdl_mute  = 1'b0;
    mdl_fixed = 1'b1;
    mdl_ready = 1'b0;
    mdl_d     = '0;
    fpu_result = '0;
    for (int i = 0; i < 4; i++) begin
      req_din1[i*32 +: 32] = d1[i];
      req_din2[i*32 +: 32] = d2[i];
      req_op[i*2 +: 2]     = 2'(i);
    end
    tick();
    do_reset();

    chk("rst_busy", 32'(busy), 0);
    chk("rst_fv", 32'(fpu_valid), 0);
    chk("rst_din1", fpu_din1, 0);
    chk("rst_rsp", 32'(rsp_valid), 0);
    chk("rst_res", rsp_result, 0);
    chk("rst_err", 32'(rsp_err), 0);

    // single ADD request, L=3
    req_valid = 4'b0001;
    #1;
    chk("t1_gnt", 32'(req_ready), 32'h1);
    tick();
    chk("t1_rdy_lo", 32'(req_ready), 0);
    req_valid = 4'b0;
    chk("t1_fv", 32'(fpu_valid), 1);
    chk("t1_din1", fpu_din1, 32'h3F800000);
    chk("t1_din2", fpu_din2, 32'h40000000);
    chk("t1_op", 32'(fpu_op_sel), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_fv_lo", 32'(fpu_valid), 0);
    tick();
    tick();
    chk("t1_rsp_early", 32'(rsp_valid), 0);
    tick();
    chk("t1_rsp", 32'(rsp_valid), 32'h1);
    chk("t1_res", rsp_result, 32'h40400000);
    chk("t1_err", 32'(rsp_err), 0);
    tick();
    chk("t1_rsp_lo", 32'(rsp_valid), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_hold", fpu_din1, 32'h3F800000);
    mdl_fixed = 1'b0;

    // all four requesters valid continuously
    do_reset();
    req_valid = 4'b1111;
    wait_rsp("rr0", 4'b0001, rx[0], 1'b0);
    wait_rsp("rr1", 4'b0010, rx[1], 1'b0);
    wait_rsp("rr2", 4'b0100, rx[2], 1'b0);
    wait_rsp("rr3", 4'b1000, rx[3], 1'b0);
    wait_rsp("rr4", 4'b0001, rx[0], 1'b0);
    req_valid = 4'b0;

    // move ptr to 3 by serving req2
    tick();
    req_valid = 4'b0100;
    #1;
    chk("p_gnt2", 32'(req_ready), 32'h4);
    tick();
    req_valid = 4'b0;
    wait_rsp("p_r2", 4'b0100, rx[2], 1'b0);
    tick();
    req_valid = 4'b1010;
    #1;
    chk("p_gnt3", 32'(req_ready), 32'h8);
    tick();
    req_valid = 4'b0010;
    wait_rsp("p_r3", 4'b1000, rx[3], 1'b0);
    wait_rsp("p_r1", 4'b0010, rx[1], 1'b0);
    req_valid = 4'b0;

    // reset during WAIT
    tick();
    lat = 10;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mr_busy", 32'(busy), 0);
    chk("mr_fv", 32'(fpu_valid), 0);
    chk("mr_din1", fpu_din1, 0);
    chk("mr_din2", fpu_din2, 0);
    chk("mr_rsp", 32'(rsp_valid), 0);
    chk("mr_res", rsp_result, 0);
    chk("mr_gnt", 32'(req_ready), 0);
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid != 4'b0) hits++;
    end
    chk("mr_no_rsp", 32'(hits), 0);

    // spurious fpu_ready in IDLE and ISSUE
    lat = 4;
    spur = 1'b1;
    tick();
    spur = 1'b0;
    tick();
    chk("sp_idle_busy", 32'(busy), 0);
    chk("sp_idle_rsp", 32'(rsp_valid), 0);
    req_valid = 4'b0010;
    spur = 1'b1;
    tick();
    req_valid = 4'b0;
    tick();
    spur = 1'b0;
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid != 4'b0) hits++;
      tick();
    end
    chk("sp_early", 32'(hits), 0);
    chk("sp_rsp", 32'(rsp_valid), 32'h2);
    chk("sp_res", rsp_result, rx[1]);

`ifdef FPU_ARB_TIMEOUT_EN
    // FPU never answers: watchdog fires 64 cycles after WAIT entry
    tick();
    mdl_mute = 1'b1;
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0;
    tick();
    hits = 0;
    for (int i = 0; i < 63; i++) begin
      tick();
      if (rsp_valid != 4'b0) hits++;
    end
    chk("to_early", 32'(hits), 0);
    tick();
    chk("to_rsp", 32'(rsp_valid), 32'h1);
    chk("to_err", 32'(rsp_err), 1);
    chk("to_res", rsp_result, 0);
    mdl_mute = 1'b0;
`endif

    // follow-up request served normally
    tick();
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b0;
    wait_rsp("post", 4'b1000, rx[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Round-robin arbiter and sequencer that shares a single, non-pipelined `fpu_top` among `NUM_REQ` requesters. Each request (two operands plus an op code) is accepted with a valid/ready handshake and issued to the FPU as a one-cycle `valid` pulse. The arbiter then waits for the FPU `ready` pulse and returns the result to the originating requester. It sits between the requester agents and `fpu_top`, and drives every FPU input.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters, range 2..8
- `DATA_W`, 32 — operand/result width (IEEE-754 single)
- `OP_W`, 2 — op-select width
- `TIMEOUT_CYC`, 64 — watchdog limit in cycles (used only with the macro)

Ports:
- `clk`  in  1  — single clock; all logic rising-edge
- `reset`  in  1  — synchronous, active-high
- `req_valid`  in  NUM_REQ  — per-requester request valid
- `req_ready`  out  NUM_REQ  — one-hot grant/accept; combinational
- `req_din1`  in  NUM_REQ*DATA_W  — packed operand 1; slice i belongs to requester i
- `req_din2`  in  NUM_REQ*DATA_W  — packed operand 2
- `req_op`  in  NUM_REQ*OP_W  — packed op select
- `rsp_valid`  out  NUM_REQ  — one-hot, one-cycle response strobe
- `rsp_result`  out  DATA_W  — result, shared by all requesters
- `rsp_err`  out  1  — timeout error, qualified by any `rsp_valid`
- `fpu_din1`, `fpu_din2`  out  DATA_W  — FPU operands
- `fpu_op_sel`  out  OP_W  — FPU op select
- `fpu_valid`  out  1  — one-cycle issue pulse
- `fpu_result`  in  DATA_W  — FPU result
- `fpu_ready`  in  1  — FPU result-valid pulse
- `busy`  out  1  — high in every state except IDLE

## Operation
FSM states: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Arbitration: grant g is the lowest index ≥ `ptr` (wrapping) with `req_valid[g]=1`.
  - `req_ready[g]=1` in that same cycle; this is the handshake.
  - The slice-g operands and op code are latched into internal registers, g is latched, and the FSM moves to ISSUE.
  - With no request, the FSM stays in IDLE and `req_ready`=0.
- **ISSUE**
  - `fpu_valid`=1 for exactly this cycle, with `fpu_din1`, `fpu_din2` and `fpu_op_sel` driven from the latched registers. Next state is WAIT.
- **WAIT**
  - When `fpu_ready`=1, `fpu_result` is captured and the FSM moves to RESP.
- **RESP**
  - `rsp_valid[g]`=1 and `rsp_result` holds the captured result.
  - Responses have no backpressure: requesters must accept in this cycle.
  - `ptr` ← (g+1) mod NUM_REQ, and the FSM returns to IDLE.
- `fpu_ready` is sampled only in WAIT. A pulse in any other state is ignored.
- `req_ready`=0 in every state other than IDLE. Requesters hold `req_valid` and data until `req_ready`. A request dropped before grant is simply not served.
- `fpu_din*` and `fpu_op_sel` hold their last values between ops.

## Timing
- Reset values: all outputs 0, state IDLE, `ptr`=0, all operand and result registers 0.
- Latency, with accept in cycle T:
  - `fpu_valid` in T+1.
  - `fpu_ready` arrives at T+1+L, where L ≥ 1 is the FPU latency.
  - `rsp_valid` in T+2+L.
- Throughput: one op per L+3 cycles.
- Registered outputs: `fpu_*`, `rsp_valid`, `rsp_result`, `rsp_err`, `busy`. Combinational output: `req_ready`.
- Simultaneous requests: exactly one grant per arbitration. With all requesters permanently valid, grants rotate 0,1,2,3,0…
- `ptr` wraps from NUM_REQ-1 to 0.
- Reset asserted mid-operation: the FSM returns to IDLE next cycle and the in-flight op is dropped with no `rsp_valid`. `fpu_top` shares the same reset.

## Configuration
- Macro: `FPU_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WAIT, cleared on entry.
  - After TIMEOUT_CYC cycles without `fpu_ready`, the FSM goes to RESP with `rsp_err`=1 and `rsp_result`=0, and `ptr` advances.
  - A late `fpu_ready` that arrives outside WAIT is ignored.
- **Undefined:**
  - No counter; WAIT can last indefinitely.
  - `rsp_err` is tied to 0.

## Structure
- Package `fpu_arb_pkg`:
  - state enum typedef `fpu_arb_state_t`
  - op encodings `FPU_OP_ADD`=0, `FPU_OP_SUB`=1, `FPU_OP_MUL`=2, `FPU_OP_DIV`=3
  - default width constants
- Sub-module `rr_arbiter`: purely combinational. Inputs are `req` vector and `ptr`; outputs are one-hot `gnt` and encoded `gnt_idx`. Instantiated once.

## Test plan
- Single request: req0 with 0x3F800000 + 0x40000000 (ADD), FPU model L=3 → `req_ready[0]` at T, `fpu_valid` at T+1, `rsp_valid[0]` at T+5 with 0x40400000.
- All four requesters valid continuously, each with distinct operands → grant order 0,1,2,3,0. Each `rsp_valid[i]` carries its own result; no two `rsp_valid` bits are ever high together.
- `ptr`=3 with req1 and req3 valid → req3 is granted first, then req1.
- Reset asserted during WAIT → next cycle all outputs are 0 and `busy`=0. No `rsp_valid` appears even when `fpu_ready` pulses afterwards.
- Spurious `fpu_ready` during IDLE and ISSUE → ignored. The result is returned only after the WAIT-state pulse.
- With `FPU_ARB_TIMEOUT_EN` and TIMEOUT_CYC=64, FPU never responding → `rsp_valid[g]`=1, `rsp_err`=1, `rsp_result`=0 exactly 64 cycles after WAIT entry. The next request is served normally.
